// File: rtl/pe_sequencer.sv
// pe_sequencer: instruction-level controller for the SIMD PE datapath.
// Decodes one opcode at a time, raises the PE control strobes at fixed
// parameterised latencies, and advances the PC only when an instruction
// retires. Operand-load flags and a saturating result-word count are tracked.
// Optional performance counters are built when PE_SEQ_PERF_CNT_EN is defined.
module pe_sequencer #(
  parameter int OPCODE_LEN  = 4,
  parameter int PE_ELEMENTS = 4,
  parameter int RAM_RD_LAT  = 1,
  parameter int STAGE1_LAT  = 2,
  parameter int STAGE2_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inst_valid,
  input  logic [OPCODE_LEN-1:0] opcode,
  output logic                  pc_en,
  output logic                  pe_issue,
  output logic [1:0]            pe_op,
  output logic                  pe_stage_1_valid,
  output logic                  pe_stage_2_valid,
  output logic                  store_result,
  output logic                  result_full,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           retired_cnt
);

  localparam int MAX_LAT_12 = (RAM_RD_LAT > STAGE1_LAT) ? RAM_RD_LAT : STAGE1_LAT;
  localparam int MAX_LAT    = (MAX_LAT_12 > STAGE2_LAT) ? MAX_LAT_12 : STAGE2_LAT;
  localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int RES_W      = $clog2(PE_ELEMENTS + 1);

  // Latency counters count down to zero, so they are loaded with LAT-1.
  localparam logic [CNT_W-1:0] RD_INIT  = CNT_W'(RAM_RD_LAT - 1);
  localparam logic [CNT_W-1:0] S1_INIT  = CNT_W'(STAGE1_LAT - 1);
  localparam logic [CNT_W-1:0] S2_INIT  = CNT_W'(STAGE2_LAT - 1);
  localparam logic [RES_W-1:0] RES_MAX  = RES_W'(PE_ELEMENTS);

  localparam logic [OPCODE_LEN-1:0] OP_NOOP    = OPCODE_LEN'(0);
  localparam logic [OPCODE_LEN-1:0] OP_ADD     = OPCODE_LEN'(1);
  localparam logic [OPCODE_LEN-1:0] OP_SUB     = OPCODE_LEN'(2);
  localparam logic [OPCODE_LEN-1:0] OP_MUL     = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_DOTP    = OPCODE_LEN'(4);
  localparam logic [OPCODE_LEN-1:0] OP_TMP_S1  = OPCODE_LEN'(5);
  localparam logic [OPCODE_LEN-1:0] OP_TMP_S2  = OPCODE_LEN'(6);
  localparam logic [OPCODE_LEN-1:0] OP_STORE   = OPCODE_LEN'(7);
  localparam logic [OPCODE_LEN-1:0] OP_STOP    = OPCODE_LEN'(8);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_A = OPCODE_LEN'(9);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_B = OPCODE_LEN'(10);

  localparam logic [1:0] PE_ADD  = 2'd0;
  localparam logic [1:0] PE_SUB  = 2'd1;
  localparam logic [1:0] PE_MUL  = 2'd2;
  localparam logic [1:0] PE_DOTP = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_WAIT_RD, S_WAIT_S1, S_WAIT_S2, S_STORE, S_ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic [RES_W-1:0] res_cnt;
  logic             a_loaded;
  logic             b_loaded;
  logic             fetch_is_b;

  assign result_full = (res_cnt == RES_MAX);

  // Main controller: state, latency timing, operand flags and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      lat_cnt          <= '0;
      res_cnt          <= '0;
      a_loaded         <= 1'b0;
      b_loaded         <= 1'b0;
      fetch_is_b       <= 1'b0;
      pc_en            <= 1'b0;
      pe_issue         <= 1'b0;
      pe_op            <= PE_ADD;
      pe_stage_1_valid <= 1'b0;
      pe_stage_2_valid <= 1'b0;
      store_result     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      // NOTE: strobes default low here and the case below overrides them; with
      // non-blocking assignments the last write in the block wins, giving clean
      // one-cycle pulses without a separate clear path.
      pc_en            <= 1'b0;
      pe_issue         <= 1'b0;
      pe_stage_1_valid <= 1'b0;
      pe_stage_2_valid <= 1'b0;
      store_result     <= 1'b0;
      done             <= 1'b0;

      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            error    <= 1'b0;
            a_loaded <= 1'b0;
            b_loaded <= 1'b0;
            res_cnt  <= '0;
          end
        end

        S_RUN: begin
          if (inst_valid) begin
            case (opcode)
              OP_NOOP, OP_TMP_S1, OP_TMP_S2: pc_en <= 1'b1;
              OP_FETCH_A, OP_FETCH_B: begin
                fetch_is_b <= (opcode == OP_FETCH_B);
                lat_cnt    <= RD_INIT;
                state      <= S_WAIT_RD;
              end
              OP_ADD, OP_SUB, OP_MUL, OP_DOTP: begin
                if (a_loaded && b_loaded) begin
                  pe_issue <= 1'b1;
                  pe_op    <= (opcode == OP_ADD) ? PE_ADD :
                              (opcode == OP_SUB) ? PE_SUB :
                              (opcode == OP_MUL) ? PE_MUL : PE_DOTP;
                  lat_cnt  <= S1_INIT;
                  state    <= S_WAIT_S1;
                end else begin
                  state <= S_ERROR;
                  busy  <= 1'b0;
                  error <= 1'b1;
                end
              end
              OP_STORE: state <= S_STORE;
              OP_STOP: begin
                pc_en <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end
              default: begin
                state <= S_ERROR;
                busy  <= 1'b0;
                error <= 1'b1;
              end
            endcase
          end
        end

        S_WAIT_RD: begin
          if (lat_cnt == '0) begin
            pc_en <= 1'b1;
            if (fetch_is_b) b_loaded <= 1'b1;
            else            a_loaded <= 1'b1;
            state <= S_RUN;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        S_WAIT_S1: begin
          if (lat_cnt == '0) begin
            pe_stage_1_valid <= 1'b1;
            if (pe_op == PE_DOTP) begin
              lat_cnt <= S2_INIT;
              state   <= S_WAIT_S2;
            end else begin
              pc_en   <= 1'b1;
              res_cnt <= RES_MAX;
              state   <= S_RUN;
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        S_WAIT_S2: begin
          if (lat_cnt == '0) begin
            pe_stage_2_valid <= 1'b1;
            pc_en            <= 1'b1;
            if (res_cnt != RES_MAX) res_cnt <= res_cnt + RES_W'(1);
            state <= S_RUN;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        S_STORE: begin
          store_result <= 1'b1;
          pc_en        <= 1'b1;
          res_cnt      <= '0;
          state        <= S_RUN;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PE_SEQ_PERF_CNT_EN
  // Performance counters: busy cycles and retired instructions, cleared on run start.
  always_ff @(posedge clk) begin
    if (rst || (start && !busy)) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (busy)  cycle_cnt   <= cycle_cnt + 32'd1;
      if (pc_en) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: reset checks, a latency table,
// hand-written corner sequences and random programs scored against a
// cycle-timeline reference model derived from the instruction latencies.
module tb_pe_sequencer;

  localparam int PE  = 4;
  localparam int RD  = 1;
  localparam int S1L = 2;
  localparam int S2L = 2;
  localparam int H   = 96;

  localparam logic [3:0] NOOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, DOTP = 4'd4;
  localparam logic [3:0] TS1 = 4'd5, TS2 = 4'd6, STR = 4'd7, STOP = 4'd8;
  localparam logic [3:0] FA = 4'd9, FB = 4'd10;

  // Bit positions inside the packed per-cycle observation vector.
  localparam int B_PC = 8, B_ISS = 7, B_S1 = 6, B_S2 = 5, B_ST = 4;
  localparam int B_DN = 3, B_BUSY = 2, B_ERR = 1, B_FULL = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        inst_valid = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        pc_en, pe_issue, pe_stage_1_valid, pe_stage_2_valid, store_result;
  logic        result_full, busy, done, error;
  logic [1:0]  pe_op;
  logic [31:0] cycle_cnt, retired_cnt;

  pe_sequencer #(
    .OPCODE_LEN(4), .PE_ELEMENTS(PE), .RAM_RD_LAT(RD), .STAGE1_LAT(S1L), .STAGE2_LAT(S2L)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .inst_valid(inst_valid), .opcode(opcode),
    .pc_en(pc_en), .pe_issue(pe_issue), .pe_op(pe_op),
    .pe_stage_1_valid(pe_stage_1_valid), .pe_stage_2_valid(pe_stage_2_valid),
    .store_result(store_result), .result_full(result_full), .busy(busy),
    .done(done), .error(error), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0]  prog_q[$];
  int          gap_q[$];
  logic [8:0]  obs[H];
  logic [1:0]  obs_op[H];
  logic [31:0] obs_cyc[H];
  logic [31:0] obs_ret[H];
  logic [8:0]  exp_v[H];
  logic [1:0]  exp_op[H];
  logic        exp_op_chk[H];

  typedef struct {
    logic [3:0] op;
    int         retire;
    int         issue;
    int         s1;
    int         s2;
    int         store;
    logic       err;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pack_outs();
    return {pc_en, pe_issue, pe_stage_1_valid, pe_stage_2_valid, store_result,
            done, busy, error, result_full};
  endfunction

  task automatic add(input logic [3:0] op, input int gap);
    prog_q.push_back(op);
    gap_q.push_back(gap);
  endtask

  task automatic clear_prog();
    prog_q.delete();
    gap_q.delete();
  endtask

  // Pulses start, then feeds the queued program: each instruction is held with
  // inst_valid high until pc_en is seen, after an optional idle gap.
  task automatic run_prog(input int ncyc);
    int idx;
    int gl;
    int n;
    n = prog_q.size();
    idx = 0;
    gl = 0;
    start = 1'b1;
    inst_valid = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      start = 1'b0;
      obs[k] = pack_outs();
      obs_op[k] = pe_op;
      obs_cyc[k] = cycle_cnt;
      obs_ret[k] = retired_cnt;
      if (k == 0) begin
        idx = 0;
        gl = (n > 0) ? gap_q[0] : 0;
      end else if (pc_en) begin
        idx++;
        gl = (idx < n) ? gap_q[idx] : 0;
      end
      if (idx >= n) inst_valid = 1'b0;
      else if (gl > 0) begin
        inst_valid = 1'b0;
        gl--;
      end else begin
        inst_valid = 1'b1;
        opcode = prog_q[idx];
      end
    end
    inst_valid = 1'b0;
  endtask

  // Reference timeline: cycle k is the k-th clock edge after the start edge.
  // Each instruction is placed on the timeline from its documented latencies.
  task automatic build_model();
    int t, r, cnt, stop_t, err_t, cur;
    int fupd[H];
    logic a, b, halted;
    logic [3:0] op;
    for (int k = 0; k < H; k++) begin
      exp_v[k] = '0;
      exp_op[k] = '0;
      exp_op_chk[k] = 1'b0;
      fupd[k] = -1;
    end
    t = 1; a = 1'b0; b = 1'b0; cnt = 0; stop_t = H; err_t = H; halted = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (!halted) begin
        t += gap_q[i];
        op = prog_q[i];
        if (op == NOOP || op == TS1 || op == TS2) begin
          if (t < H) exp_v[t][B_PC] = 1'b1;
          t += 1;
        end else if (op == FA || op == FB) begin
          if (t + RD < H) exp_v[t + RD][B_PC] = 1'b1;
          if (op == FA) a = 1'b1; else b = 1'b1;
          t += RD + 1;
        end else if (op >= ADD && op <= DOTP) begin
          if (!(a && b)) begin
            err_t = t; stop_t = t; halted = 1'b1;
          end else begin
            r = t + S1L;
            if (op == DOTP) begin
              r += S2L;
              if (r < H) exp_v[r][B_S2] = 1'b1;
              cnt = (cnt < PE) ? cnt + 1 : PE;
            end else begin
              cnt = PE;
            end
            if (t < H) exp_v[t][B_ISS] = 1'b1;
            if (t + S1L < H) exp_v[t + S1L][B_S1] = 1'b1;
            if (r < H) begin
              exp_v[r][B_PC] = 1'b1;
              fupd[r] = cnt;
            end
            for (int x = t; x <= r && x < H; x++) begin
              exp_op_chk[x] = 1'b1;
              exp_op[x] = 2'(op - ADD);
            end
            t = r + 1;
          end
        end else if (op == STR) begin
          cnt = 0;
          if (t + 1 < H) begin
            exp_v[t + 1][B_ST] = 1'b1;
            exp_v[t + 1][B_PC] = 1'b1;
            fupd[t + 1] = 0;
          end
          t += 2;
        end else if (op == STOP) begin
          if (t < H) begin
            exp_v[t][B_PC] = 1'b1;
            exp_v[t][B_DN] = 1'b1;
          end
          stop_t = t; halted = 1'b1;
        end else begin
          err_t = t; stop_t = t; halted = 1'b1;
        end
      end
    end
    cur = 0;
    for (int k = 0; k < H; k++) begin
      if (fupd[k] >= 0) cur = fupd[k];
      exp_v[k][B_FULL] = (cur == PE);
      exp_v[k][B_BUSY] = (k < stop_t);
      exp_v[k][B_ERR]  = (k >= err_t);
    end
  endtask

  task automatic compare_model(input string tag);
    build_model();
    for (int k = 0; k < H; k++) begin
      check($sformatf("%s cyc%0d flags", tag, k), 32'(obs[k]), 32'(exp_v[k]));
      if (exp_op_chk[k])
        check($sformatf("%s cyc%0d pe_op", tag, k), 32'(obs_op[k]), 32'(exp_op[k]));
    end
  endtask

  function automatic int first_at(input int bitpos, input int from);
    for (int k = from; k < H; k++)
      if (obs[k][bitpos]) return k - from;
    return -1;
  endfunction

  logic [31:0] perf_exp;
  logic        seen;

  initial begin
    tbl[0]  = '{NOOP, 0, -1, -1, -1, -1, 1'b0};
    tbl[1]  = '{TS1,  0, -1, -1, -1, -1, 1'b0};
    tbl[2]  = '{TS2,  0, -1, -1, -1, -1, 1'b0};
    tbl[3]  = '{ADD,  2,  0,  2, -1, -1, 1'b0};
    tbl[4]  = '{SUB,  2,  0,  2, -1, -1, 1'b0};
    tbl[5]  = '{MUL,  2,  0,  2, -1, -1, 1'b0};
    tbl[6]  = '{DOTP, 4,  0,  2,  4, -1, 1'b0};
    tbl[7]  = '{STR,  1, -1, -1, -1,  1, 1'b0};
    tbl[8]  = '{FA,   1, -1, -1, -1, -1, 1'b0};
    tbl[9]  = '{4'd12, -1, -1, -1, -1, -1, 1'b1};
    tbl[10] = '{4'd15, -1, -1, -1, -1, -1, 1'b1};

    // Reset with start held high: reset must win and clear everything.
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset flags", 32'(pack_outs()), 32'd0);
    check("reset pe_op", 32'(pe_op), 32'd0);
    check("reset cycle_cnt", cycle_cnt, 32'd0);
    check("reset retired_cnt", retired_cnt, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle after reset busy", 32'(busy), 32'd0);

    // Basic program: FETCH_A, FETCH_B, ADD, STORE_RESULT, STOP.
    clear_prog();
    add(FA, 0); add(FB, 0); add(ADD, 0); add(STR, 0); add(STOP, 0);
    run_prog(H);
    check("basic fetch_a pc_en", 32'(obs[2][B_PC]), 32'd1);
    check("basic fetch_b pc_en", 32'(obs[4][B_PC]), 32'd1);
    check("basic add issue", 32'(obs[5][B_ISS]), 32'd1);
    check("basic add s1+pc", 32'({obs[7][B_S1], obs[7][B_PC]}), 32'd3);
    check("basic full after add", 32'(obs[7][B_FULL]), 32'd1);
    check("basic store strobe", 32'(obs[9][B_ST]), 32'd1);
    check("basic full after store", 32'(obs[9][B_FULL]), 32'd0);
    check("basic done", 32'(obs[10][B_DN]), 32'd1);
    check("basic busy at done", 32'(obs[11][B_BUSY]), 32'd0);
    compare_model("basic");

    // Latency table: op decoded at cycle 5 after two fetches.
    for (int i = 0; i < 11; i++) begin
      clear_prog();
      add(FA, 0); add(FB, 0); add(tbl[i].op, 0); add(STOP, 0);
      run_prog(H);
      check($sformatf("tbl op%0d retire", tbl[i].op), first_at(B_PC, 5), tbl[i].retire);
      check($sformatf("tbl op%0d issue", tbl[i].op), first_at(B_ISS, 5), tbl[i].issue);
      check($sformatf("tbl op%0d s1", tbl[i].op), first_at(B_S1, 5), tbl[i].s1);
      check($sformatf("tbl op%0d s2", tbl[i].op), first_at(B_S2, 5), tbl[i].s2);
      check($sformatf("tbl op%0d store", tbl[i].op), first_at(B_ST, 5), tbl[i].store);
      check($sformatf("tbl op%0d error", tbl[i].op), 32'(obs[H-1][B_ERR]), 32'(tbl[i].err));
    end

    // Five DOTPs: result count saturates at PE_ELEMENTS.
    clear_prog();
    add(FA, 0); add(FB, 0);
    for (int i = 0; i < 5; i++) add(DOTP, 0);
    add(STOP, 0);
    run_prog(H);
    check("dotp1 s2 at decode+4", 32'(obs[9][B_S2]), 32'd1);
    check("dotp full before 4th", 32'(obs[23][B_FULL]), 32'd0);
    check("dotp full after 4th", 32'(obs[24][B_FULL]), 32'd1);
    check("dotp full after 5th", 32'(obs[30][B_FULL]), 32'd1);
    compare_model("dotp5");

    // MUL without operands: error, no issue, not busy; restart clears error.
    clear_prog();
    add(MUL, 0);
    run_prog(H);
    seen = 1'b0;
    for (int k = 0; k < H; k++) seen |= obs[k][B_ISS];
    check("mul noload issue seen", 32'(seen), 32'd0);
    check("mul noload error", 32'(obs[H-1][B_ERR]), 32'd1);
    check("mul noload busy", 32'(obs[H-1][B_BUSY]), 32'd0);
    clear_prog();
    add(STOP, 2);
    run_prog(H);
    check("restart error cleared", 32'(obs[0][B_ERR]), 32'd0);
    check("restart busy", 32'(obs[0][B_BUSY]), 32'd1);

    // Illegal opcode, and idle inst_valid cycles in RUN.
    clear_prog();
    add(NOOP, 3); add(4'd12, 0); add(STOP, 0);
    run_prog(H);
    check("gap cyc1-3 quiet", 32'({obs[1][8:3], obs[2][8:3], obs[3][8:3]}), 32'd0);
    check("gap busy held", 32'(obs[3][B_BUSY]), 32'd1);
    check("illegal error", 32'(obs[5][B_ERR]), 32'd1);
    check("illegal no pc_en", 32'(obs[5][B_PC]), 32'd0);
    compare_model("illegal");

    // Reset during WAIT_S1 of an ADD drops the stage-1 strobe.
    clear_prog();
    add(FA, 0); add(FB, 0); add(ADD, 0); add(STOP, 0);
    run_prog(7);
    check("rst-mid add issued", 32'(obs[5][B_ISS]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst-mid all flags", 32'(pack_outs()), 32'd0);
    check("rst-mid pe_op", 32'(pe_op), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= pe_stage_1_valid | busy | pc_en;
    end
    check("rst-mid no late strobes", 32'(seen), 32'd0);

    // Performance counters over NOOP, NOOP, STOP.
`ifdef PE_SEQ_PERF_CNT_EN
    perf_exp = 32'd3;
`else
    perf_exp = 32'd0;
`endif
    clear_prog();
    add(NOOP, 0); add(NOOP, 0); add(STOP, 0);
    run_prog(H);
    check("perf done cycle", 32'(obs[3][B_DN]), 32'd1);
    check("perf cycle_cnt", obs_cyc[4], perf_exp);
    check("perf retired_cnt", obs_ret[4], perf_exp);
    check("perf cycle_cnt idle", obs_cyc[H-1], perf_exp);
    compare_model("perf");

    // Random programs scored against the timeline model.
    for (int r = 0; r < 40; r++) begin
      int len;
      int pick;
      logic [3:0] op;
      clear_prog();
      if ($urandom % 4 != 0) begin
        add(FA, $urandom_range(0, 2));
        add(FB, $urandom_range(0, 2));
      end
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        pick = $urandom % 20;
        if (pick < 11)      op = 4'(pick);
        else if (pick < 13) op = 4'(11 + $urandom % 5);
        else                op = 4'(1 + $urandom % 4);
        add(op, $urandom_range(0, 2));
      end
      add(STOP, $urandom_range(0, 2));
      run_prog(H);
      compare_model($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Instruction-level controller for the SIMD PE datapath. Sits between the program counter / instruction memory and the PE pipeline, and decodes each opcode. It advances the PC only when an instruction retires, and generates the PE control strobes with fixed, parameterised latencies: issue, stage-1 valid, stage-2 valid and result store. It tracks operand-load state and flags illegal sequences.

## Interface
- OPCODE_LEN, 4, opcode width
- PE_ELEMENTS, 4, lanes per vector; sizes result counter
- RAM_RD_LAT, 1, cycles from FETCH_A/FETCH_B decode to data valid (>=1)
- STAGE1_LAT, 2, cycles from pe_issue to pe_stage_1_valid (>=1)
- STAGE2_LAT, 2, cycles from pe_stage_1_valid to pe_stage_2_valid for DOTP (>=1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; begins execution from IDLE/ERROR
- inst_valid  in  1  opcode input holds a fresh instruction
- opcode  in  OPCODE_LEN  current instruction opcode
- pc_en  out  1  one-cycle PC advance (retire) strobe
- pe_issue  out  1  one-cycle compute launch strobe
- pe_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DOTP; stable from issue to retire
- pe_stage_1_valid  out  1  one-cycle stage-1 result strobe
- pe_stage_2_valid  out  1  one-cycle stage-2 (reduction) result strobe
- store_result  out  1  one-cycle result-RAM write strobe
- result_full  out  1  result vector holds PE_ELEMENTS valid words
- busy  out  1  high in any state except IDLE/ERROR
- done  out  1  one-cycle pulse on STOP retire
- error  out  1  sticky fault flag
- cycle_cnt, retired_cnt  out  32 each  perf counters (see Configuration)

## Operation
- Opcode map: NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, STORE_TEMP_S1=5, STORE_TEMP_S2=6, STORE_RESULT=7, STOP=8, FETCH_A=9, FETCH_B=10, 11..15 illegal.
- States: IDLE, RUN, WAIT_RD, WAIT_S1, WAIT_S2, STORE, ERROR.
- IDLE: start -> RUN; clears a_loaded, b_loaded, result count, error. start ignored while busy.
- RUN: decodes only when inst_valid=1.
  - NOOP/STORE_TEMP_S1/STORE_TEMP_S2: pc_en same cycle; stay RUN.
  - FETCH_A/FETCH_B: -> WAIT_RD. After RAM_RD_LAT cycles: pc_en, set a_loaded/b_loaded, -> RUN.
  - ADD/SUB/MUL/DOTP with a_loaded and b_loaded both set: pe_issue, latch pe_op, -> WAIT_S1.
  - ADD/SUB/MUL/DOTP with either operand flag clear: -> ERROR, no issue.
  - STORE_RESULT: -> STORE.
  - STOP: pc_en, done, -> IDLE.
  - Illegal opcode: -> ERROR.
- WAIT_S1: pe_stage_1_valid when the counter expires.
  - ADD/SUB/MUL: pc_en in the same cycle, result count := PE_ELEMENTS, -> RUN.
  - DOTP: -> WAIT_S2.
- WAIT_S2: pe_stage_2_valid and pc_en when the counter expires. Result count += 1, saturating at PE_ELEMENTS. -> RUN.
- STORE: store_result and pc_en for one cycle; result count := 0; -> RUN.
- result_full = (result count == PE_ELEMENTS).
- ERROR: error=1, busy=0, all strobes 0. Exit only via rst, or via start (clears error, -> RUN).
- Operand flags persist across computes; they are cleared only by start/rst.

## Timing
- Reset: every output 0, state IDLE, all counters/flags 0. Any in-flight valid strobe is dropped.
- rst asserted with start in the same cycle: rst wins.
- Decode cycle = cycle 0.
  - FETCH: pc_en at cycle RAM_RD_LAT.
  - ADD/SUB/MUL: pe_issue at 0; pe_stage_1_valid and pc_en at STAGE1_LAT.
  - DOTP: pe_stage_1_valid at STAGE1_LAT; pe_stage_2_valid and pc_en at STAGE1_LAT+STAGE2_LAT.
  - STORE_RESULT: store_result and pc_en at 1.
  - Single-cycle ops: pc_en at 0.
- At most one instruction in flight. opcode and inst_valid are ignored outside RUN. Upstream deasserts inst_valid until the post-pc_en instruction is present.
- busy rises the cycle after start; it falls the cycle after done or on entry to ERROR.
- The strobes pc_en, pe_issue, pe_stage_1_valid, pe_stage_2_valid, store_result and done are never high for two consecutive cycles from a single instruction.

## Configuration
- PE_SEQ_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle busy=1.
  - retired_cnt increments on every pc_en.
  - Both are cleared on start/rst and wrap at 2^32.
- PE_SEQ_PERF_CNT_EN undefined: both ports remain present, tied to 0, and no counter logic is synthesised.

## Test plan
- Defaults; start; program FETCH_A, FETCH_B, ADD, STORE_RESULT, STOP:
  - FETCH_A/FETCH_B: pc_en 1 cycle after each decode.
  - ADD: pe_issue at t, pe_stage_1_valid and pc_en at t+2; result_full=1.
  - STORE_RESULT: store_result 1 cycle after decode; result_full=0.
  - STOP: done pulse; busy=0.
- FETCH_A, FETCH_B, then 5×DOTP: each DOTP has pe_stage_2_valid at decode+4. result_full rises after the 4th DOTP and stays 1 after the 5th (saturates).
- start, then MUL with no prior FETCH: error=1, pe_issue never asserts, busy=0. A subsequent start clears error and busy=1.
- Opcode 12 in RUN: ERROR entered, no pc_en. inst_valid=0 for 3 cycles in RUN: no strobes, state held.
- rst asserted at WAIT_S1 cycle 1 of ADD: next cycle all outputs 0, pe_stage_1_valid never fires, IDLE.
- With PE_SEQ_PERF_CNT_EN, program NOOP, NOOP, STOP: retired_cnt=3 and cycle_cnt=3 after done. Without the macro both read 0.
